// File: rtl/writeback_unit.sv
// writeback_unit
// ---------------------------------------------------------------------------
// Write-side initiator for the processor register file. Results come from
// the ALU and from the load path. Loads are formatted on arrival and queued
// in a small circular FIFO; a queued load always wins over the ALU. The
// chosen result passes through one registered write stage that drives the
// register file's single write port. The unit also returns operands to
// decode: x0 reads as zero, and the write stage can optionally be bypassed.
//
// Configuration macro:
//   WB_FORWARD_EN  when defined, the registered write stage is forwarded onto
//                  operand1/operand2 when its address matches the read
//                  address. When undefined, decode must stall one cycle on a
//                  RAW hazard against writeAddr.
//
// Parameters:
//   LOAD_DEPTH   load FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, arstn              clock (rising edge), async active-low reset
//   aluValid/aluReady       ALU result handshake; aluRd, aluData payload
//   loadValid/loadReady     load result handshake; loadRd, loadData,
//                           loadFunct3 (RV32I funct3), loadOffset (addr[1:0])
//   writeEn/Addr/Data       register file write port
//   readAddr1/2, readData1/2  register file read ports (addresses shared)
//   operand1/2              corrected operands to decode
//   busy                    FIFO non-empty or a write is in flight
// ---------------------------------------------------------------------------
module writeback_unit #(
    parameter int LOAD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        aluValid,
    output logic        aluReady,
    input  logic [4:0]  aluRd,
    input  logic [31:0] aluData,
    input  logic        loadValid,
    output logic        loadReady,
    input  logic [4:0]  loadRd,
    input  logic [31:0] loadData,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadOffset,
    output logic        writeEn,
    output logic [4:0]  writeAddr,
    output logic [31:0] writeData,
    input  logic [4:0]  readAddr1,
    input  logic [4:0]  readAddr2,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic        busy
);

    localparam int PTR_W = $clog2(LOAD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LOAD_DEPTH);

    // Load FIFO storage and bookkeeping
    logic [4:0]       fifo_rd_q   [LOAD_DEPTH];
    logic [4:0]       fifo_rd_d   [LOAD_DEPTH];
    logic [31:0]      fifo_data_q [LOAD_DEPTH];
    logic [31:0]      fifo_data_d [LOAD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered write stage
    logic             write_en_q, write_en_d;
    logic [4:0]       write_addr_q, write_addr_d;
    logic [31:0]      write_data_q, write_data_d;

    logic             push;
    logic             pop;
    logic             take_alu;
    logic [31:0]      load_formatted;

    // Byte/half extraction and extension for RV32I load types. Unknown
    // funct3 codes are treated as a full word.
    function automatic logic [31:0] format_load(
        input logic [31:0] raw,
        input logic [2:0]  funct3,
        input logic [1:0]  offset
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = raw[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            3'b000:  format_load = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  format_load = {24'h0, byte_sel};
            3'b001:  format_load = {{16{half_sel[15]}}, half_sel};
            3'b101:  format_load = {16'h0, half_sel};
            default: format_load = raw;
        endcase
    endfunction

    // Handshakes depend only on registered state. Because pop is decided
    // from count_q, a load pushed into an empty FIFO cannot also be popped
    // in the same cycle.
    assign loadReady      = (count_q != FULL_COUNT);
    assign aluReady       = (count_q == '0);
    assign push           = loadValid && loadReady;
    assign pop            = (count_q != '0);
    assign take_alu       = !pop && aluValid;
    assign load_formatted = format_load(loadData, loadFunct3, loadOffset);

    // FIFO next state: formatted data is written at push time
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = loadRd;
            fifo_data_d[wr_ptr_q] = load_formatted;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Write stage next state: rd == 0 results are consumed but not written;
    // when idle the address/data hold their previous values.
    always_comb begin
        write_en_d   = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        if (pop) begin
            write_en_d   = (fifo_rd_q[rd_ptr_q] != 5'd0);
            write_addr_d = fifo_rd_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
        end else if (take_alu) begin
            write_en_d   = (aluRd != 5'd0);
            write_addr_d = aluRd;
            write_data_d = aluData;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < LOAD_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            fifo_rd_q    <= fifo_rd_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign writeEn   = write_en_q;
    assign writeAddr = write_addr_q;
    assign writeData = write_data_q;
    assign busy      = (count_q != '0) || write_en_q;

    // Operand correction: x0 always reads zero
    always_comb begin
        operand1 = readData1;
        operand2 = readData2;
`ifdef WB_FORWARD_EN
        if (write_en_q && (write_addr_q == readAddr1)) begin
            operand1 = write_data_q;
        end
        if (write_en_q && (write_addr_q == readAddr2)) begin
            operand2 = write_data_q;
        end
`endif
        if (readAddr1 == 5'd0) begin
            operand1 = '0;
        end
        if (readAddr2 == 5'd0) begin
            operand2 = '0;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: a transaction-level model (a queue of
// formatted loads plus the expected write-port state) is stepped alongside
// the DUT with directed and $urandom stimulus.
module tb_writeback_unit;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        arstn;
    logic        aluValid;
    logic        aluReady;
    logic [4:0]  aluRd;
    logic [31:0] aluData;
    logic        loadValid;
    logic        loadReady;
    logic [4:0]  loadRd;
    logic [31:0] loadData;
    logic [2:0]  loadFunct3;
    logic [1:0]  loadOffset;
    logic        writeEn;
    logic [4:0]  writeAddr;
    logic [31:0] writeData;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;

    int compareCount;
    int mismatchCount;

    // Reference state
    entry_t      loadQueue[$];
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;

    writeback_unit #(.LOAD_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .arstn      (arstn),
        .aluValid   (aluValid),
        .aluReady   (aluReady),
        .aluRd      (aluRd),
        .aluData    (aluData),
        .loadValid  (loadValid),
        .loadReady  (loadReady),
        .loadRd     (loadRd),
        .loadData   (loadData),
        .loadFunct3 (loadFunct3),
        .loadOffset (loadOffset),
        .writeEn    (writeEn),
        .writeAddr  (writeAddr),
        .writeData  (writeData),
        .readAddr1  (readAddr1),
        .readAddr2  (readAddr2),
        .readData1  (readData1),
        .readData2  (readData2),
        .operand1   (operand1),
        .operand2   (operand2),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load formatting from the ISA definition: shift the wanted byte/half
    // down, mask, then subtract 2^n when a signed value has its top bit set.
    function automatic logic [31:0] refFormat(input logic [31:0] raw, input logic [2:0] f3,
                                              input logic [1:0] off);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = longint'((raw >> (8 * int'(off))) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = longint'((raw >> (off[1] ? 16 : 0)) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(raw);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] refOperand(input logic [4:0] ra, input logic [31:0] rdata);
        if (ra == 5'd0) return 32'h0;
`ifdef WB_FORWARD_EN
        if (expWe && expAddr == ra) return expData;
`endif
        return rdata;
    endfunction

    task automatic modelReset();
        loadQueue.delete();
        expWe   = 1'b0;
        expAddr = 5'd0;
        expData = 32'h0;
    endtask

    task automatic checkComb();
        checkOutput("loadReady", 32'(loadReady), 32'(loadQueue.size() != DEPTH));
        checkOutput("aluReady",  32'(aluReady),  32'(loadQueue.size() == 0));
        checkOutput("busy",      32'(busy),      32'(loadQueue.size() != 0 || expWe));
        checkOutput("operand1",  operand1, refOperand(readAddr1, readData1));
        checkOutput("operand2",  operand2, refOperand(readAddr2, readData2));
    endtask

    task automatic checkWritePort();
        checkOutput("writeEn",   32'(writeEn),   32'(expWe));
        checkOutput("writeAddr", 32'(writeAddr), 32'(expAddr));
        checkOutput("writeData", writeData, expData);
    endtask

    // One clock cycle: inputs are already driven (after a negedge). Check
    // combinational outputs, advance the model at the rising edge, then
    // check the write port at the following falling edge.
    task automatic applyStimulus();
        int     sizeBefore;
        entry_t e;
        #1;
        checkComb();
        @(posedge clk);
        sizeBefore = loadQueue.size();
        if (sizeBefore != 0) begin
            e       = loadQueue.pop_front();
            expWe   = (e.rd != 5'd0);
            expAddr = e.rd;
            expData = e.data;
        end else if (aluValid) begin
            expWe   = (aluRd != 5'd0);
            expAddr = aluRd;
            expData = aluData;
        end else begin
            expWe = 1'b0;
        end
        if (loadValid && sizeBefore != DEPTH) begin
            e.rd   = loadRd;
            e.data = refFormat(loadData, loadFunct3, loadOffset);
            loadQueue.push_back(e);
        end
        @(negedge clk);
        checkWritePort();
    endtask

    task automatic idleInputs();
        aluValid  = 1'b0;
        loadValid = 1'b0;
    endtask

    // Single load on an otherwise idle unit; the formatted word must appear
    // on the write port two edges after the push.
    task automatic directedLoad(input string tag, input logic [2:0] f3, input logic [1:0] off,
                                input logic [31:0] expected);
        loadValid  = 1'b1;
        loadRd     = 5'd9;
        loadData   = 32'h80FF_7F01;
        loadFunct3 = f3;
        loadOffset = off;
        applyStimulus();
        loadValid = 1'b0;
        applyStimulus();
        checkOutput({tag, "_we"}, 32'(writeEn), 32'd1);
        checkOutput(tag, writeData, expected);
        applyStimulus();
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        arstn      = 1'b0;
        aluValid   = 1'b0;
        aluRd      = 5'd0;
        aluData    = 32'h0;
        loadValid  = 1'b0;
        loadRd     = 5'd0;
        loadData   = 32'h0;
        loadFunct3 = 3'd0;
        loadOffset = 2'd0;
        readAddr1  = 5'd0;
        readAddr2  = 5'd0;
        readData1  = 32'h0;
        readData2  = 32'h0;
        modelReset();

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_writeEn",   32'(writeEn),   32'd0);
        checkOutput("rst_writeAddr", 32'(writeAddr), 32'd0);
        checkOutput("rst_writeData", writeData,      32'd0);
        checkOutput("rst_loadReady", 32'(loadReady), 32'd1);
        checkOutput("rst_aluReady",  32'(aluReady),  32'd1);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        arstn = 1'b1;
        applyStimulus();

        // ALU write, then rd == 0 discard
        aluValid = 1'b1; aluRd = 5'd5; aluData = 32'h1234_5678;
        applyStimulus();
        checkOutput("alu_we",   32'(writeEn),   32'd1);
        checkOutput("alu_addr", 32'(writeAddr), 32'd5);
        checkOutput("alu_data", writeData,      32'h1234_5678);
        aluRd = 5'd0; aluData = 32'hAAAA_5555;
        applyStimulus();
        checkOutput("alu_x0_we", 32'(writeEn), 32'd0);
        idleInputs();
        applyStimulus();

        // Load formatting
        directedLoad("lb_off3",  3'b000, 2'd3, 32'hFFFF_FF80);
        directedLoad("lbu_off2", 3'b100, 2'd2, 32'h0000_00FF);
        directedLoad("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
        directedLoad("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
        directedLoad("lw",       3'b010, 2'd1, 32'h80FF_7F01);

        // Priority: ALU held valid while three loads arrive back to back
        aluValid = 1'b1; aluRd = 5'd3; aluData = 32'hA1A1_A1A1;
        for (int i = 0; i < 3; i++) begin
            loadValid  = 1'b1;
            loadRd     = 5'(10 + i);
            loadData   = 32'h1000_0000 + 32'(i);
            loadFunct3 = 3'b010;
            applyStimulus();
        end
        loadValid = 1'b0;
        repeat (4) applyStimulus();
        idleInputs();
        repeat (2) applyStimulus();

        // Forwarding
        aluValid = 1'b1; aluRd = 5'd7; aluData = 32'hDEAD_BEEF;
        applyStimulus();
        aluValid  = 1'b0;
        readAddr1 = 5'd7; readData1 = 32'h0;
        readAddr2 = 5'd0; readData2 = 32'h55;
        #1;
`ifdef WB_FORWARD_EN
        checkOutput("fwd_op1", operand1, 32'hDEAD_BEEF);
`else
        checkOutput("fwd_op1", operand1, 32'h0);
`endif
        checkOutput("fwd_op2", operand2, 32'h0);
        applyStimulus();

        // Reset mid-operation with a load queued and a write pending
        loadValid = 1'b1; loadRd = 5'd20; loadData = 32'h0BAD_F00D; loadFunct3 = 3'b010;
        aluValid = 1'b1; aluRd = 5'd21; aluData = 32'h1111_2222;
        applyStimulus();
        applyStimulus();
        #2;
        arstn = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_writeEn",   32'(writeEn),   32'd0);
        checkOutput("midrst_loadReady", 32'(loadReady), 32'd1);
        checkOutput("midrst_aluReady",  32'(aluReady),  32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_edge_we",   32'(writeEn), 32'd0);
        checkOutput("midrst_edge_busy", 32'(busy),    32'd0);
        idleInputs();
        arstn = 1'b1;
        applyStimulus();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            aluValid   = ($urandom_range(0, 3) != 0);
            aluRd      = 5'($urandom_range(0, 7));
            aluData    = $urandom;
            loadValid  = ($urandom_range(0, 2) == 0);
            loadRd     = 5'($urandom_range(0, 7));
            loadData   = $urandom;
            loadFunct3 = 3'($urandom_range(0, 7));
            loadOffset = 2'($urandom_range(0, 3));
            readAddr1  = 5'($urandom_range(0, 7));
            readAddr2  = 5'($urandom_range(0, 7));
            readData1  = $urandom;
            readData2  = $urandom;
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
